// File: rtl/sd_card_pkg.sv
// -----------------------------------------------------------------------------
// sd_card_pkg
// Shared definitions for the SD SPI-mode sector controller:
//   - SD command indices and their CRC bytes
//   - expected R1 response values
//   - the 5-bit sequencer state encoding
//   - the command descriptor (frame, expected R1, trailing byte count)
//   - build_cmd(): assembles the 48-bit {index, arg, crc} frame
// No ports; imported by sd_card_sec_ctrl.
// -----------------------------------------------------------------------------
package sd_card_pkg;

    // Command indices (raw index byte; sd_card_cmd adds start/transmission bits)
    localparam logic [7:0] CMD0_IDX  = 8'd0;
    localparam logic [7:0] CMD8_IDX  = 8'd8;
    localparam logic [7:0] CMD16_IDX = 8'd16;
    localparam logic [7:0] CMD17_IDX = 8'd17;
    localparam logic [7:0] CMD24_IDX = 8'd24;
    localparam logic [7:0] CMD41_IDX = 8'd41;
    localparam logic [7:0] CMD55_IDX = 8'd55;

    // Only CMD0 and CMD8 are checked by a card in SPI mode; all others use a dummy CRC.
    localparam logic [7:0] CRC_CMD0  = 8'h95;
    localparam logic [7:0] CRC_CMD8  = 8'h87;
    localparam logic [7:0] CRC_DUMMY = 8'hFF;

    localparam logic [7:0] R1_IDLE   = 8'h01;
    localparam logic [7:0] R1_READY  = 8'h00;

    // CMD8 argument: 2.7-3.6 V range plus check pattern 0xAA
    localparam logic [31:0] CMD8_ARG  = 32'h0000_01AA;
    localparam logic [31:0] BLOCK_LEN = 32'd512;

    typedef enum logic [4:0] {
        S_CMD0   = 5'd0,
        S_CMD8   = 5'd1,
        S_CMD55  = 5'd2,
        S_ACMD41 = 5'd3,
        S_CMD16  = 5'd4,
        S_READY  = 5'd5,
        S_RD_CMD = 5'd6,
        S_RD_BLK = 5'd7,
        S_WR_CMD = 5'd8,
        S_WR_BLK = 5'd9,
        S_FAIL   = 5'd10
    } state_t;

    typedef struct packed {
        logic [47:0] cmd;
        logic [7:0]  r1;
        logic [15:0] len;
    } cmd_desc_t;

    function automatic logic [47:0] build_cmd(input logic [7:0] idx, input logic [31:0] arg);
        logic [7:0] crc;
        crc = (idx == CMD0_IDX) ? CRC_CMD0 :
              (idx == CMD8_IDX) ? CRC_CMD8 : CRC_DUMMY;
        return {idx, arg, crc};
    endfunction

endpackage

// File: rtl/sd_card_sec_ctrl_if.sv
// -----------------------------------------------------------------------------
// sd_card_sec_ctrl_if
// Bus between the sector sequencer (master) and sd_card_cmd (slave).
//   spi_clk_div         master->slave  SPI clock divider
//   cmd_req             master->slave  held high until cmd_req_ack
//   cmd                 master->slave  {index[7:0], arg[31:0], crc[7:0]}
//   cmd_r1              master->slave  expected R1
//   cmd_data_len        master->slave  trailing response bytes
//   cmd_req_ack         slave->master  command finished (1 cycle)
//   cmd_req_error       slave->master  R1 mismatch, valid with cmd_req_ack
//   block_read_req      master->slave  held until block_read_req_ack
//   block_read_req_ack  slave->master
//   block_write_req     master->slave  held until block_write_req_ack
//   block_write_req_ack slave->master
// -----------------------------------------------------------------------------
interface sd_card_sec_ctrl_if;
    logic [15:0] spi_clk_div;
    logic        cmd_req;
    logic [47:0] cmd;
    logic [7:0]  cmd_r1;
    logic [15:0] cmd_data_len;
    logic        cmd_req_ack;
    logic        cmd_req_error;
    logic        block_read_req;
    logic        block_read_req_ack;
    logic        block_write_req;
    logic        block_write_req_ack;

    modport master (
        output spi_clk_div, cmd_req, cmd, cmd_r1, cmd_data_len,
               block_read_req, block_write_req,
        input  cmd_req_ack, cmd_req_error, block_read_req_ack, block_write_req_ack
    );

    modport slave (
        input  spi_clk_div, cmd_req, cmd, cmd_r1, cmd_data_len,
               block_read_req, block_write_req,
        output cmd_req_ack, cmd_req_error, block_read_req_ack, block_write_req_ack
    );
endinterface

// File: rtl/sd_card_sec_ctrl.sv
// -----------------------------------------------------------------------------
// sd_card_sec_ctrl
// Sequencer above sd_card_cmd: runs SD SPI-mode power-up (CMD0, CMD8,
// CMD55+ACMD41, CMD16) on a slow SPI clock, then serves single-sector
// read/write requests as CMD17/CMD24 followed by a block transfer handshake
// on the fast SPI clock. Sector data bytes do not pass through here.
//
// Ports:
//   sys_clk, rst          clock, synchronous active-high reset
//   sd_init_done          level, card ready for sector ops
//   sd_init_error         level, init failed (sticky until rst)
//   sd_sec_read/_addr     read request (level) and sector number
//   sd_sec_read_end       1-cycle pulse, read block finished
//   sd_sec_write/_addr    write request (level) and sector number
//   sd_sec_write_end      1-cycle pulse, write block finished
//   sd_sec_error          1-cycle pulse, CMD17/CMD24 rejected, op aborted
//   cmd_bus               master side of sd_card_sec_ctrl_if
//
// Build option: define SD_SDHC_EN for SDHC/SDXC cards (CMD8 issued, HCS set
// in ACMD41, block addressing). Undefined: standard-capacity cards with byte
// addressing and CMD8 skipped.
// -----------------------------------------------------------------------------
module sd_card_sec_ctrl
    import sd_card_pkg::*;
#(
    parameter logic [15:0] INIT_CLK_DIV = 16'd200,
    parameter logic [15:0] FAST_CLK_DIV = 16'd2,
    parameter logic [7:0]  CMD0_RETRY   = 8'd16,
    parameter logic [15:0] ACMD41_RETRY = 16'd2000
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    output logic                      sd_init_done,
    output logic                      sd_init_error,
    input  logic                      sd_sec_read,
    input  logic [31:0]               sd_sec_read_addr,
    output logic                      sd_sec_read_end,
    input  logic                      sd_sec_write,
    input  logic [31:0]               sd_sec_write_addr,
    output logic                      sd_sec_write_end,
    output logic                      sd_sec_error,
    sd_card_sec_ctrl_if.master        cmd_bus
);

`ifdef SD_SDHC_EN
    localparam state_t      AFTER_CMD0 = S_CMD8;
    localparam logic [31:0] ACMD41_ARG = 32'h4000_0000;   // HCS
`else
    localparam state_t      AFTER_CMD0 = S_CMD55;
    localparam logic [31:0] ACMD41_ARG = 32'd0;
`endif

    // Sector number to command argument. Standard-capacity cards take a byte
    // address, so the sector is scaled by 512 and bits [31:23] shift out.
    function automatic logic [31:0] addr_map(input logic [31:0] sector);
`ifdef SD_SDHC_EN
        return sector;
`else
        return sector << 9;
`endif
    endfunction

    state_t      state, state_nxt;
    logic        cmd_req_q, cmd_req_nxt;
    cmd_desc_t   desc_q, desc_nxt;
    logic        blk_rd_q, blk_rd_nxt;
    logic        blk_wr_q, blk_wr_nxt;
    logic        rd_end_q, rd_end_nxt;
    logic        wr_end_q, wr_end_nxt;
    logic        sec_err_q, sec_err_nxt;
    logic        init_done_q, init_done_nxt;
    logic [7:0]  cmd0_cnt, cmd0_cnt_nxt;
    logic [15:0] acmd41_cnt, acmd41_cnt_nxt;
    logic [31:0] addr_q, addr_nxt;

    cmd_desc_t   cur_desc;
    logic        is_cmd_state;
    logic        cmd_done, cmd_ok, cmd_bad;

    // Command each command-issuing state sends; non-command states send nothing.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
        is_cmd_state = 1'b1;
        cur_desc     = '0;
        unique case (state)
            S_CMD0:   cur_desc = '{cmd: build_cmd(CMD0_IDX,  32'd0),            r1: R1_IDLE,  len: 16'd0};
            S_CMD8:   cur_desc = '{cmd: build_cmd(CMD8_IDX,  CMD8_ARG),         r1: R1_IDLE,  len: 16'd4};
            S_CMD55:  cur_desc = '{cmd: build_cmd(CMD55_IDX, 32'd0),            r1: R1_IDLE,  len: 16'd0};
            S_ACMD41: cur_desc = '{cmd: build_cmd(CMD41_IDX, ACMD41_ARG),       r1: R1_READY, len: 16'd0};
            S_CMD16:  cur_desc = '{cmd: build_cmd(CMD16_IDX, BLOCK_LEN),        r1: R1_READY, len: 16'd0};
            S_RD_CMD: cur_desc = '{cmd: build_cmd(CMD17_IDX, addr_map(addr_q)), r1: R1_READY, len: 16'd0};
            S_WR_CMD: cur_desc = '{cmd: build_cmd(CMD24_IDX, addr_map(addr_q)), r1: R1_READY, len: 16'd0};
            default:  is_cmd_state = 1'b0;
        endcase
    end

    assign cmd_done = cmd_req_q & cmd_bus.cmd_req_ack;
    assign cmd_ok   = cmd_done & ~cmd_bus.cmd_req_error;
    assign cmd_bad  = cmd_done &  cmd_bus.cmd_req_error;

    always_comb begin
        state_nxt      = state;
        cmd_req_nxt    = cmd_req_q;
        desc_nxt       = desc_q;
        blk_rd_nxt     = blk_rd_q;
        blk_wr_nxt     = blk_wr_q;
        rd_end_nxt     = 1'b0;
        wr_end_nxt     = 1'b0;
        sec_err_nxt    = 1'b0;
        init_done_nxt  = init_done_q;
        cmd0_cnt_nxt   = cmd0_cnt;
        acmd41_cnt_nxt = acmd41_cnt;
        addr_nxt       = addr_q;

        // Frame and request rise together; the frame stays frozen until the ack.
        if (is_cmd_state && !cmd_req_q) begin
            cmd_req_nxt = 1'b1;
            desc_nxt    = cur_desc;
        end
        if (cmd_done) begin
            cmd_req_nxt = 1'b0;
        end

        unique case (state)
            S_CMD0: begin
                if (cmd_ok) begin
                    state_nxt = AFTER_CMD0;
                end else if (cmd_bad) begin
                    if (cmd0_cnt != 8'hFF) cmd0_cnt_nxt = cmd0_cnt + 8'd1;
                    // cmd0_cnt counts earlier failures, so this is the CMD0_RETRY-th attempt.
                    if (cmd0_cnt >= CMD0_RETRY - 8'd1) state_nxt = S_FAIL;
                end
            end
            S_CMD8: begin
                if (cmd_ok)       state_nxt = S_CMD55;
                else if (cmd_bad) state_nxt = S_FAIL;
            end
            S_CMD55: begin
                // A card that already left idle answers 00 and shows up as an error; harmless.
                if (cmd_done) state_nxt = S_ACMD41;
            end
            S_ACMD41: begin
                if (cmd_ok) begin
                    state_nxt = S_CMD16;
                end else if (cmd_bad) begin
                    if (acmd41_cnt != 16'hFFFF) acmd41_cnt_nxt = acmd41_cnt + 16'd1;
                    state_nxt = (acmd41_cnt >= ACMD41_RETRY - 16'd1) ? S_FAIL : S_CMD55;
                end
            end
            S_CMD16: begin
                if (cmd_ok) begin
                    state_nxt     = S_READY;
                    init_done_nxt = 1'b1;
                end else if (cmd_bad) begin
                    state_nxt = S_FAIL;
                end
            end
            S_READY: begin
                if (sd_sec_read) begin
                    addr_nxt  = sd_sec_read_addr;
                    state_nxt = S_RD_CMD;
                end else if (sd_sec_write) begin
                    addr_nxt  = sd_sec_write_addr;
                    state_nxt = S_WR_CMD;
                end
            end
            S_RD_CMD: begin
                if (cmd_ok) begin
                    state_nxt = S_RD_BLK;
                end else if (cmd_bad) begin
                    sec_err_nxt = 1'b1;
                    state_nxt   = S_READY;
                end
            end
            S_RD_BLK: begin
                if (blk_rd_q && cmd_bus.block_read_req_ack) begin
                    blk_rd_nxt = 1'b0;
                    rd_end_nxt = 1'b1;
                    state_nxt  = S_READY;
                end else begin
                    blk_rd_nxt = 1'b1;
                end
            end
            S_WR_CMD: begin
                if (cmd_ok) begin
                    state_nxt = S_WR_BLK;
                end else if (cmd_bad) begin
                    sec_err_nxt = 1'b1;
                    state_nxt   = S_READY;
                end
            end
            S_WR_BLK: begin
                if (blk_wr_q && cmd_bus.block_write_req_ack) begin
                    blk_wr_nxt = 1'b0;
                    wr_end_nxt = 1'b1;
                    state_nxt  = S_READY;
                end else begin
                    blk_wr_nxt = 1'b1;
                end
            end
            default: ;   // S_FAIL is terminal until rst
        endcase
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state       <= S_CMD0;
            cmd_req_q   <= 1'b0;
            desc_q      <= '0;
            blk_rd_q    <= 1'b0;
            blk_wr_q    <= 1'b0;
            rd_end_q    <= 1'b0;
            wr_end_q    <= 1'b0;
            sec_err_q   <= 1'b0;
            init_done_q <= 1'b0;
            cmd0_cnt    <= '0;
            acmd41_cnt  <= '0;
            addr_q      <= '0;
        end else begin
            state       <= state_nxt;
            cmd_req_q   <= cmd_req_nxt;
            desc_q      <= desc_nxt;
            blk_rd_q    <= blk_rd_nxt;
            blk_wr_q    <= blk_wr_nxt;
            rd_end_q    <= rd_end_nxt;
            wr_end_q    <= wr_end_nxt;
            sec_err_q   <= sec_err_nxt;
            init_done_q <= init_done_nxt;
            cmd0_cnt    <= cmd0_cnt_nxt;
            acmd41_cnt  <= acmd41_cnt_nxt;
            addr_q      <= addr_nxt;
        end
    end

    assign sd_init_done     = init_done_q;
    assign sd_init_error    = (state == S_FAIL);
    assign sd_sec_read_end  = rd_end_q;
    assign sd_sec_write_end = wr_end_q;
    assign sd_sec_error     = sec_err_q;

    // Fast clock from the moment init completes and for every sector op after it.
    assign cmd_bus.spi_clk_div     = init_done_q ? FAST_CLK_DIV : INIT_CLK_DIV;
    assign cmd_bus.cmd_req         = cmd_req_q;
    assign cmd_bus.cmd             = desc_q.cmd;
    assign cmd_bus.cmd_r1          = desc_q.r1;
    assign cmd_bus.cmd_data_len    = desc_q.len;
    assign cmd_bus.block_read_req  = blk_rd_q;
    assign cmd_bus.block_write_req = blk_wr_q;

endmodule

// File: tb/tb_sd_card_sec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sd_card_sec_ctrl
// Bench for sd_card_sec_ctrl with a behavioural sd_card_cmd/card model that
// answers commands and block handshakes after random delays. Expected command
// frames are built from the SD command rules (index, argument, CRC, R1, length).
// Honours SD_SDHC_EN the same way as the design build.
// -----------------------------------------------------------------------------
module tb_sd_card_sec_ctrl;
    localparam logic [15:0] INIT_DIV = 16'd200;
    localparam logic [15:0] FAST_DIV = 16'd2;

    typedef struct packed {
        logic [47:0] cmd;
        logic [7:0]  r1;
        logic [15:0] len;
    } log_t;

    logic        sys_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        sd_init_done, sd_init_error;
    logic        sd_sec_read = 1'b0, sd_sec_write = 1'b0;
    logic [31:0] sd_sec_read_addr = '0, sd_sec_write_addr = '0;
    logic        sd_sec_read_end, sd_sec_write_end, sd_sec_error;

    sd_card_sec_ctrl_if bus();

    sd_card_sec_ctrl dut (
        .sys_clk           (sys_clk),
        .rst               (rst),
        .sd_init_done      (sd_init_done),
        .sd_init_error     (sd_init_error),
        .sd_sec_read       (sd_sec_read),
        .sd_sec_read_addr  (sd_sec_read_addr),
        .sd_sec_read_end   (sd_sec_read_end),
        .sd_sec_write      (sd_sec_write),
        .sd_sec_write_addr (sd_sec_write_addr),
        .sd_sec_write_end  (sd_sec_write_end),
        .sd_sec_error      (sd_sec_error),
        .cmd_bus           (bus.master)
    );

    always #5 sys_clk = ~sys_clk;

    int   n_checks = 0;
    int   n_fail   = 0;

    // Card model knobs
    int   cmd0_err_left    = 0;
    int   acmd41_busy_left = 0;
    bit   cmd17_err        = 1'b0;
    bit   blk_hold         = 1'b0;

    log_t cmd_log[$];

    int   n_rd_end = 0, n_wr_end = 0, n_sec_err = 0, n_blk_rd = 0, n_blk_wr = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rules for a command frame
    function automatic log_t exp_entry(input logic [7:0] idx, input logic [31:0] arg,
                                       input logic [7:0] r1, input logic [15:0] len);
        logic [7:0] crc;
        if (idx == 8'd0)      crc = 8'h95;
        else if (idx == 8'd8) crc = 8'h87;
        else                  crc = 8'hFF;
        return '{cmd: {idx, arg, crc}, r1: r1, len: len};
    endfunction

    function automatic logic [31:0] map_addr(input logic [31:0] sector);
`ifdef SD_SDHC_EN
        return sector;
`else
        return sector * 32'd512;
`endif
    endfunction

    function automatic logic [31:0] acmd41_arg();
`ifdef SD_SDHC_EN
        return 32'h4000_0000;
`else
        return 32'd0;
`endif
    endfunction

    // Command responder (behavioural sd_card_cmd + card)
    initial begin : cmd_responder
        logic err;
        int   dly;
        bit   aborted;
        bus.cmd_req_ack   = 1'b0;
        bus.cmd_req_error = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!rst && bus.cmd_req) begin
                cmd_log.push_back('{cmd: bus.cmd, r1: bus.cmd_r1, len: bus.cmd_data_len});
                err = 1'b0;
                case (bus.cmd[47:40])
                    8'd0:  if (cmd0_err_left > 0)    begin err = 1'b1; cmd0_err_left--;    end
                    8'd41: if (acmd41_busy_left > 0) begin err = 1'b1; acmd41_busy_left--; end
                    8'd55: err = ($urandom_range(1, 0) == 1);
                    8'd17: err = cmd17_err;
                    default: err = 1'b0;
                endcase
                dly     = $urandom_range(3, 0);
                aborted = 1'b0;
                for (int k = 0; k < dly; k++) begin
                    @(negedge sys_clk);
                    if (rst) aborted = 1'b1;
                end
                if (!aborted && !rst) begin
                    bus.cmd_req_ack   = 1'b1;
                    bus.cmd_req_error = err;
                    @(negedge sys_clk);
                    bus.cmd_req_ack   = 1'b0;
                    bus.cmd_req_error = 1'b0;
                end
            end
        end
    end

    // Block transfer responder
    initial begin : blk_responder
        int dly;
        bit is_rd;
        bus.block_read_req_ack  = 1'b0;
        bus.block_write_req_ack = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!rst && !blk_hold && (bus.block_read_req || bus.block_write_req)) begin
                is_rd = bus.block_read_req;
                dly   = $urandom_range(4, 0);
                repeat (dly) @(negedge sys_clk);
                if (!rst) begin
                    if (is_rd) bus.block_read_req_ack  = 1'b1;
                    else       bus.block_write_req_ack = 1'b1;
                    @(negedge sys_clk);
                    bus.block_read_req_ack  = 1'b0;
                    bus.block_write_req_ack = 1'b0;
                end
            end
        end
    end

    // Pulse / request-edge monitor, sampled just after the clock edge
    initial begin : monitor
        logic prev_rd, prev_wr;
        prev_rd = 1'b0;
        prev_wr = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (rst) begin
                prev_rd = 1'b0;
                prev_wr = 1'b0;
            end else begin
                if (sd_sec_read_end === 1'b1)  n_rd_end++;
                if (sd_sec_write_end === 1'b1) n_wr_end++;
                if (sd_sec_error === 1'b1)     n_sec_err++;
                if (bus.block_read_req === 1'b1 && !prev_rd)  n_blk_rd++;
                if (bus.block_write_req === 1'b1 && !prev_wr) n_blk_wr++;
                prev_rd = bus.block_read_req;
                prev_wr = bus.block_write_req;
            end
        end
    end

    task automatic wait_log(input int n, input int budget);
        int c = 0;
        while (cmd_log.size() < n && c < budget) begin
            @(negedge sys_clk);
            c++;
        end
    endtask

    task automatic wait_ops(input int n, input int budget);
        int c = 0;
        while ((n_rd_end + n_wr_end + n_sec_err) < n && c < budget) begin
            @(negedge sys_clk);
            c++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_init_done"},  sd_init_done,         1'b0);
        check({tag, "_init_error"}, sd_init_error,        1'b0);
        check({tag, "_rd_end"},     sd_sec_read_end,      1'b0);
        check({tag, "_wr_end"},     sd_sec_write_end,     1'b0);
        check({tag, "_sec_err"},    sd_sec_error,         1'b0);
        check({tag, "_cmd_req"},    bus.cmd_req,          1'b0);
        check({tag, "_cmd"},        bus.cmd,              48'd0);
        check({tag, "_r1"},         bus.cmd_r1,           8'd0);
        check({tag, "_len"},        bus.cmd_data_len,     16'd0);
        check({tag, "_blk_rd"},     bus.block_read_req,   1'b0);
        check({tag, "_blk_wr"},     bus.block_write_req,  1'b0);
        check({tag, "_clk_div"},    bus.spi_clk_div,      INIT_DIV);
    endtask

    // Release reset and check the full init command sequence for a card busy `busy` times.
    task automatic run_init(input int busy, input string tag);
        log_t exp_q[$];
        exp_q.push_back(exp_entry(8'd0, 32'd0, 8'h01, 16'd0));
`ifdef SD_SDHC_EN
        exp_q.push_back(exp_entry(8'd8, 32'h1AA, 8'h01, 16'd4));
`endif
        for (int i = 0; i <= busy; i++) begin
            exp_q.push_back(exp_entry(8'd55, 32'd0, 8'h01, 16'd0));
            exp_q.push_back(exp_entry(8'd41, acmd41_arg(), 8'h00, 16'd0));
        end
        exp_q.push_back(exp_entry(8'd16, 32'd512, 8'h00, 16'd0));

        cmd_log.delete();
        acmd41_busy_left = busy;
        cmd0_err_left    = 0;
        @(negedge sys_clk);
        rst = 1'b0;
        wait_log(1, 20);
        check({tag, "_slow_clk"},  bus.spi_clk_div, INIT_DIV);
        check({tag, "_not_done"},  sd_init_done,    1'b0);
        wait_log(exp_q.size(), 2000);
        repeat (8) @(negedge sys_clk);
        check({tag, "_ncmd"}, cmd_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++)
            check($sformatf("%s_cmd%0d", tag, i), cmd_log[i], exp_q[i]);
        check({tag, "_done"},     sd_init_done,    1'b1);
        check({tag, "_no_error"}, sd_init_error,   1'b0);
        check({tag, "_fast_clk"}, bus.spi_clk_div, FAST_DIV);
    endtask

    task automatic do_op(input bit is_wr, input logic [31:0] sector, input bit exp_err, input string tag);
        int   b_log, b_rd, b_wr, b_err, b_brd, b_bwr;
        log_t exp;
        b_log = cmd_log.size();
        b_rd  = n_rd_end;  b_wr  = n_wr_end;  b_err = n_sec_err;
        b_brd = n_blk_rd;  b_bwr = n_blk_wr;
        exp   = exp_entry(is_wr ? 8'd24 : 8'd17, map_addr(sector), 8'h00, 16'd0);
        @(negedge sys_clk);
        if (is_wr) begin sd_sec_write = 1'b1; sd_sec_write_addr = sector; end
        else       begin sd_sec_read  = 1'b1; sd_sec_read_addr  = sector; end
        @(negedge sys_clk);
        sd_sec_read  = 1'b0;
        sd_sec_write = 1'b0;
        wait_ops(b_rd + b_wr + b_err + 1, 200);
        repeat (3) @(negedge sys_clk);
        check({tag, "_ncmd"}, cmd_log.size(), b_log + 1);
        if (cmd_log.size() > b_log) check({tag, "_cmd"}, cmd_log[b_log], exp);
        check({tag, "_rd_end"},  n_rd_end  - b_rd,  (!is_wr && !exp_err) ? 1 : 0);
        check({tag, "_wr_end"},  n_wr_end  - b_wr,  ( is_wr && !exp_err) ? 1 : 0);
        check({tag, "_sec_err"}, n_sec_err - b_err, exp_err ? 1 : 0);
        check({tag, "_blk_rd"},  n_blk_rd  - b_brd, (!is_wr && !exp_err) ? 1 : 0);
        check({tag, "_blk_wr"},  n_blk_wr  - b_bwr, ( is_wr && !exp_err) ? 1 : 0);
    endtask

    initial begin : main
        int          b_log, b_rd, b_wr, b_ops, b_wend, b_bwr;
        logic [31:0] ra, wa;

        // Reset state
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("reset");

        // Init with card busy three times
        run_init(3, "init_busy3");

        // Directed sector ops
        do_op(1'b0, 32'h0000_1234, 1'b0, "read_1234");
        do_op(1'b1, 32'h0000_0005, 1'b0, "write_5");

        // Random sector ops
        for (int i = 0; i < 6; i++)
            do_op(1'($urandom_range(1, 0)), $urandom, 1'b0, $sformatf("rand_op%0d", i));

        // Read and write requested together: read wins, write follows while still requested
        ra    = $urandom;
        wa    = $urandom;
        b_log = cmd_log.size();
        b_rd  = n_rd_end;
        b_wr  = n_wr_end;
        b_ops = n_rd_end + n_wr_end + n_sec_err;
        @(negedge sys_clk);
        sd_sec_read = 1'b1;  sd_sec_read_addr  = ra;
        sd_sec_write = 1'b1; sd_sec_write_addr = wa;
        @(negedge sys_clk);
        sd_sec_read = 1'b0;
        wait_ops(b_ops + 1, 200);
        @(negedge sys_clk);
        sd_sec_write = 1'b0;
        wait_ops(b_ops + 2, 200);
        repeat (3) @(negedge sys_clk);
        check("both_ncmd", cmd_log.size(), b_log + 2);
        if (cmd_log.size() > b_log + 1) begin
            check("both_first_cmd17",  cmd_log[b_log],     exp_entry(8'd17, map_addr(ra), 8'h00, 16'd0));
            check("both_second_cmd24", cmd_log[b_log + 1], exp_entry(8'd24, map_addr(wa), 8'h00, 16'd0));
        end
        check("both_rd_end", n_rd_end - b_rd, 1);
        check("both_wr_end", n_wr_end - b_wr, 1);

        // CMD17 rejected by the card
        cmd17_err = 1'b1;
        do_op(1'b0, $urandom, 1'b1, "cmd17_err");
        cmd17_err = 1'b0;

        // Reset while the write block handshake is pending
        blk_hold = 1'b1;
        b_bwr    = n_blk_wr;
        b_wend   = n_wr_end;
        @(negedge sys_clk);
        sd_sec_write = 1'b1; sd_sec_write_addr = $urandom;
        @(negedge sys_clk);
        sd_sec_write = 1'b0;
        for (int c = 0; c < 100 && n_blk_wr == b_bwr; c++) @(negedge sys_clk);
        check("wrblk_reached", n_blk_wr - b_bwr, 1);
        rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        check_reset_outputs("rst_mid_wr");
        check("rst_mid_wr_no_end", n_wr_end - b_wend, 0);
        blk_hold = 1'b0;
        run_init($urandom_range(4, 0), "reinit");

        // CMD0 never answered correctly
        @(negedge sys_clk);
        rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        cmd_log.delete();
        cmd0_err_left = 16;
        rst = 1'b0;
        wait_log(16, 600);
        repeat (60) @(negedge sys_clk);
        check("cmd0_fail_ncmd", cmd_log.size(), 16);
        if (cmd_log.size() > 15)
            check("cmd0_fail_last", cmd_log[15], exp_entry(8'd0, 32'd0, 8'h01, 16'd0));
        check("cmd0_fail_error", sd_init_error, 1'b1);
        check("cmd0_fail_done",  sd_init_done,  1'b0);
        check("cmd0_fail_idle",  bus.cmd_req,   1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
